// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
package mult_ctrl_pkg;

   localparam int unsigned MinWaitDef = 2;
   localparam int unsigned MaxCycDef  = 34;
   localparam int unsigned NumReq     = 2;
   localparam int unsigned CntW       = 6;
   localparam int unsigned OpW        = 32;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StRun,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: ptr selects which requester wins a tie.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (!ptr) begin
         if (req[0]) begin
            grant = 2'b01;
         end else if (req[1]) begin
            grant = 2'b10;
         end
      end else begin
         if (req[1]) begin
            grant = 2'b10;
         end else if (req[0]) begin
            grant = 2'b01;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier between two requesters: round-robin accept,
// start pulse, bounded wait for the product, then a held one-hot response.
module mult_arbiter
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned MIN_WAIT = MinWaitDef,
   parameter int unsigned MAX_CYC  = MaxCycDef
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NumReq-1:0]       req_valid,
   output logic [NumReq-1:0]       req_ready,
   input  logic [NumReq*OpW-1:0]   req_a,
   input  logic [NumReq*OpW-1:0]   req_b,
   output logic [NumReq-1:0]       rsp_valid,
   input  logic [NumReq-1:0]       rsp_ready,
   output logic [2*OpW-1:0]        rsp_data,
   output logic                    mul_start,
   output logic [OpW-1:0]          mul_a,
   output logic [OpW-1:0]          mul_b,
   input  logic [2*OpW-1:0]        mul_res,
   input  logic                    mul_done,
   output logic                    busy
);

   localparam logic [CntW-1:0] MinWaitCnt = CntW'(MIN_WAIT);
   localparam logic [CntW-1:0] MaxCycCnt  = CntW'(MAX_CYC);

   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [2*OpW-1:0]   result_q;
   logic [OpW-1:0]     op_a_q;
   logic [OpW-1:0]     op_b_q;
   logic               id_q;
   logic               ptr_q;
   logic [NumReq-1:0]  grant;
   logic               done_hit;

   rr_arbiter2 u_rr_arbiter2 (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   // Reset gates the combinational accept so nothing is granted while held in reset.
   assign req_ready = (reset && (state_q == StIdle)) ? grant : '0;

   assign done_hit  = (mul_done && (cnt_q >= MinWaitCnt)) || (cnt_q == MaxCycCnt);

   assign rsp_valid = (state_q == StResp) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data  = result_q;
   assign mul_start = (state_q == StStart);
   assign mul_a     = op_a_q;
   assign mul_b     = op_b_q;
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         result_q <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         id_q     <= 1'b0;
         ptr_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant != 2'b00) begin
                  id_q    <= grant[1];
                  op_a_q  <= grant[1] ? req_a[2*OpW-1:OpW] : req_a[OpW-1:0];
                  op_b_q  <= grant[1] ? req_b[2*OpW-1:OpW] : req_b[OpW-1:0];
                  // Favour the other requester next time.
                  ptr_q   <= ~grant[1];
                  state_q <= StStart;
               end
            end
            StStart: begin
               cnt_q   <= '0;
               state_q <= StRun;
            end
            StRun: begin
               if (done_hit) begin
                  result_q <= mul_res;
                  state_q  <= StResp;
               end else if (cnt_q != MaxCycCnt) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               if (rsp_ready[id_q]) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier and a response scoreboard.
module tb_mult_arbiter;

   localparam int unsigned MinWait = 2;
   localparam int unsigned MaxCyc  = 34;

   typedef struct packed {
      logic        id;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [63:0] req_a = '0;
   logic [63:0] req_b = '0;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready = 2'b11;
   logic [63:0] rsp_data;
   logic        mul_start;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_res;
   logic        mul_done;
   logic        busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rsp_cnt = 0;

   // 0: done after done_dly RUN cycles, 1: done tied 0, 2: done tied 1
   int          mode = 2;
   int unsigned done_dly = 0;
   logic [31:0] m = '0;
   logic signed [63:0] prod;

   exp_t exp_q[$];
   exp_t mon_e;

   mult_arbiter #(
      .MIN_WAIT (MinWait),
      .MAX_CYC  (MaxCyc)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_res   (mul_res),
      .mul_done  (mul_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (mul_start) m <= '0;
      else m <= m + 32'd1;
   end

   always_comb begin
      prod     = longint'($signed(mul_a)) * longint'($signed(mul_b));
      mul_done = 1'b0;
      mul_res  = 64'hBAD0_BAD0_BAD0_BAD0;
      case (mode)
         0: begin
            mul_done = (m >= done_dly);
            if (mul_done) mul_res = prod;
         end
         1: mul_res = {32'hC0DE_0000, m};
         default: begin
            mul_done = 1'b1;
            mul_res  = prod;
         end
      endcase
   end

   // Scoreboard: every response handshake pops and compares one expectation.
   always @(negedge clk) begin
      if (reset === 1'b1 && (rsp_valid & rsp_ready) != 2'b00) begin
         rsp_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected rsp_valid=%b rsp_data=%h required=no response",
                     rsp_valid, rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (rsp_valid !== (mon_e.id ? 2'b10 : 2'b01) || rsp_data !== mon_e.data) begin
               failures++;
               $display("FAIL rsp_scoreboard rsp_valid=%b rsp_data=%h required valid=%b data=%h",
                        rsp_valid, rsp_data, (mon_e.id ? 2'b10 : 2'b01), mon_e.data);
            end
         end
      end
   end

   task automatic do_accept(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp_data, input bit push, output int acc);
      int n;
      logic [1:0] exp_rdy;
      exp_t e;
      n = 0;
      exp_rdy = (id != 0) ? 2'b10 : 2'b01;
      req_a[id*32 +: 32] = a;
      req_b[id*32 +: 32] = b;
      req_valid[id] = 1'b1;
      if (push) begin
         e.id = (id != 0);
         e.data = exp_data;
         exp_q.push_back(e);
      end
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (req_ready != 2'b00) break;
      end
      checks++;
      if (req_ready !== exp_rdy) begin
         failures++;
         $display("FAIL accept_req%0d req_ready=%b required=%b", id, req_ready, exp_rdy);
      end
      acc = cyc;
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_rsp(output int v);
      int n;
      n = 0;
      v = -1000;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (rsp_valid != 2'b00) begin
            v = cyc;
            break;
         end
      end
      checks++;
      if (v < 0) begin
         failures++;
         $display("FAIL rsp_timeout rsp_valid=%b required=nonzero within 100 cycles", rsp_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 2'b11;
      req_a = {32'd9, 32'd8};
      req_b = {32'd7, 32'd6};
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
         failures++;
         $display("FAIL reset_handshake req_ready=%b rsp_valid=%b required=00 00",
                  req_ready, rsp_valid);
      end
      checks++;
      if (mul_start !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0) begin
         failures++;
         $display("FAIL reset_mul start=%b a=%h b=%h required=0 0 0", mul_start, mul_a, mul_b);
      end
      checks++;
      if (busy !== 1'b0 || rsp_data !== 64'd0) begin
         failures++;
         $display("FAIL reset_status busy=%b rsp_data=%h required=0 0", busy, rsp_data);
      end
      req_valid = 2'b00;
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_back_to_back();
      int got;
      int n;
      logic exp_id;
      exp_t e;
      got = 0;
      n = 0;
      exp_id = 1'b0;
      mode = 2;
      rsp_ready = 2'b11;
      req_a = {32'hFFFF_FFFC, 32'd3};
      req_b = {32'd9, 32'd7};
      req_valid = 2'b11;
      while (got < 6 && n < 300) begin
         @(negedge clk);
         n++;
         if (req_ready != 2'b00) begin
            checks++;
            if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
               failures++;
               $display("FAIL rr_order grant%0d req_ready=%b required=%b",
                        got, req_ready, (exp_id ? 2'b10 : 2'b01));
            end
            e.id = exp_id;
            e.data = exp_id ? 64'hFFFF_FFFF_FFFF_FFDC : 64'd21;
            exp_q.push_back(e);
            exp_id = ~exp_id;
            got++;
            if (got == 6) begin
               @(posedge clk); #1;
               req_valid = 2'b00;
            end
         end
      end
      checks++;
      if (got != 6) begin
         failures++;
         $display("FAIL rr_accepts got=%0d required=6", got);
      end
      n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL rr_drain pending=%0d required=0", exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int acc;
      int v;
      mode = 2;
      rsp_ready = 2'b11;
      do_accept(0, 32'd15, 32'd13, 64'd195, 1'b1, acc);
      @(negedge clk);
      checks++;
      if ({mul_start, busy, req_ready} !== 4'b1100 || mul_a !== 32'd15 || mul_b !== 32'd13) begin
         failures++;
         $display("FAIL start_cycle start=%b busy=%b ready=%b a=%0d b=%0d required=1 1 00 15 13",
                  mul_start, busy, req_ready, mul_a, mul_b);
      end
      wait_rsp(v);
      checks++;
      if (v - acc != int'(MinWait) + 3) begin
         failures++;
         $display("FAIL min_latency latency=%0d required=%0d", v - acc, MinWait + 3);
      end
      checks++;
      if (rsp_valid !== 2'b01 || rsp_data !== 64'd195) begin
         failures++;
         $display("FAIL basic_rsp rsp_valid=%b rsp_data=%0d required=01 195", rsp_valid, rsp_data);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00 || rsp_data !== 64'd195) begin
         failures++;
         $display("FAIL idle_retain busy=%b rsp_valid=%b rsp_data=%0d required=0 00 195",
                  busy, rsp_valid, rsp_data);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_signed();
      int acc;
      int v;
      mode = 0;
      done_dly = 5;
      rsp_ready = 2'b11;
      do_accept(1, 32'hFFFF_FFF1, 32'd13, 64'hFFFF_FFFF_FFFF_FF3D, 1'b1, acc);
      wait_rsp(v);
      checks++;
      if (rsp_valid !== 2'b10 || rsp_data !== 64'hFFFF_FFFF_FFFF_FF3D) begin
         failures++;
         $display("FAIL signed_rsp rsp_valid=%b rsp_data=%h required=10 ffffffffffffff3d",
                  rsp_valid, rsp_data);
      end
      checks++;
      if (v - acc != 8) begin
         failures++;
         $display("FAIL signed_latency latency=%0d required=8", v - acc);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      int acc;
      int v;
      int cnt0;
      exp_t e;
      mode = 2;
      rsp_ready = 2'b00;
      do_accept(1, 32'd100, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FED4, 1'b1, acc);
      wait_rsp(v);
      @(posedge clk); #1;
      req_a[31:0] = 32'd6;
      req_b[31:0] = 32'd7;
      req_valid[0] = 1'b1;
      e.id = 1'b0;
      e.data = 64'd42;
      exp_q.push_back(e);
      // Non-owner accept must be ignored.
      rsp_ready = 2'b01;
      cnt0 = rsp_cnt;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 2'b10 || rsp_data !== 64'hFFFF_FFFF_FFFF_FED4 || req_ready !== 2'b00) begin
            failures++;
            $display("FAIL hold_cycle%0d rsp_valid=%b rsp_data=%h req_ready=%b required=10 fffffffffffffed4 00",
                     i, rsp_valid, rsp_data, req_ready);
         end
      end
      @(posedge clk); #1;
      rsp_ready = 2'b10;
      @(negedge clk); #1;
      checks++;
      if (rsp_cnt != cnt0 + 1) begin
         failures++;
         $display("FAIL hold_release_count completions=%0d required=%0d", rsp_cnt - cnt0, 1);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00 || req_ready !== 2'b01) begin
         failures++;
         $display("FAIL hold_single_completion rsp_valid=%b req_ready=%b required=00 01",
                  rsp_valid, req_ready);
      end
      acc = cyc;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      rsp_ready = 2'b11;
      wait_rsp(v);
      checks++;
      if (v - acc != int'(MinWait) + 3) begin
         failures++;
         $display("FAIL waiter_latency latency=%0d required=%0d", v - acc, MinWait + 3);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_timeout();
      int acc;
      int v;
      mode = 1;
      rsp_ready = 2'b11;
      do_accept(0, 32'd5, 32'd6, {32'hC0DE_0000, 32'd34}, 1'b1, acc);
      wait_rsp(v);
      checks++;
      if (v - acc != int'(MaxCyc) + 3) begin
         failures++;
         $display("FAIL timeout_latency latency=%0d required=%0d", v - acc, MaxCyc + 3);
      end
      @(posedge clk); #1;
      mode = 2;
      do_accept(1, 32'hFFFF_FFF9, 32'hFFFF_FFF7, 64'd63, 1'b1, acc);
      wait_rsp(v);
      checks++;
      if (v - acc != int'(MinWait) + 3) begin
         failures++;
         $display("FAIL done_tied_latency latency=%0d required=%0d", v - acc, MinWait + 3);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int acc;
      int v;
      mode = 0;
      done_dly = 20;
      rsp_ready = 2'b11;
      do_accept(0, 32'd11, 32'd12, 64'd0, 1'b0, acc);
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy busy=%b required=1", busy);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || mul_start !== 1'b0 || mul_a !== 32'd0 || mul_b !== 32'd0 ||
          rsp_valid !== 2'b00 || rsp_data !== 64'd0 || req_ready !== 2'b00) begin
         failures++;
         $display("FAIL reset_async busy=%b start=%b a=%h b=%h rsp_valid=%b rsp_data=%h ready=%b required=all 0",
                  busy, mul_start, mul_a, mul_b, rsp_valid, rsp_data, req_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 2'b00 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold%0d rsp_valid=%b busy=%b required=00 0", i, rsp_valid, busy);
         end
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_idle busy=%b required=0", busy);
      end
      @(posedge clk); #1;
      mode = 2;
      do_accept(0, 32'd11, 32'd12, 64'd132, 1'b1, acc);
      wait_rsp(v);
      checks++;
      if (v - acc != int'(MinWait) + 3) begin
         failures++;
         $display("FAIL post_reset_latency latency=%0d required=%0d", v - acc, MinWait + 3);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_basic();
      test_signed();
      test_hold();
      test_timeout();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time=%0t required=finish before limit", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter MIN_WAIT, default 2: RUN cycles during which mul_done is ignored.
REQ-002 SHALL have parameter MAX_CYC, default 34: RUN cycle count at which completion is forced.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  2  per-requester operation request.
REQ-007 SHALL have port req_ready  output  2  per-requester accept.
REQ-008 SHALL have port req_a  input  64  {req1 opA, req0 opA}, signed 32b each.
REQ-009 SHALL have port req_b  input  64  {req1 opB, req0 opB}, signed 32b each.
REQ-010 SHALL have port rsp_valid  output  2  one-hot result-valid to the owning requester.
REQ-011 SHALL have port rsp_ready  input  2  per-requester result accept.
REQ-012 SHALL have port rsp_data  output  64  signed product, shared by both requesters.
REQ-013 SHALL have port mul_start  output  1  drives the shift-add multiplier's active-high reset/start.
REQ-014 SHALL have ports mul_a, mul_b  output  32 each  multiplier operands.
REQ-015 SHALL have port mul_res  input  64  multiplier product.
REQ-016 SHALL have port mul_done  input  1  multiplier res_ok.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, START, RUN, RESP.
REQ-019 In IDLE with any req_valid, SHALL grant one requester and drive req_ready high for the granted requester only, combinationally, for that cycle.
- On that accept, SHALL latch its operands and requester id, then go to START.
REQ-020 Arbitration SHALL be round-robin.
- Pointer updates on each accept.
- Reset pointer favours requester 0 on a tie.
REQ-021 req_ready SHALL be 0 in START, RUN and RESP.
- Requests arriving mid-operation wait; the arbiter does not drop or queue them.
REQ-022 START SHALL last exactly one cycle with mul_start=1, then go to RUN with the cycle counter cleared to 0.
REQ-023 mul_a and mul_b SHALL hold the latched operands, stable, from START through RESP.
REQ-024 In RUN, the counter SHALL increment each cycle.
- Completion occurs when (mul_done=1 and count>=MIN_WAIT) or count==MAX_CYC.
- On completion, SHALL capture mul_res into the result register and go to RESP.
REQ-025 In RESP, SHALL drive rsp_valid[id]=1 with rsp_data = captured result, held until rsp_ready[id]=1.
- Then go to IDLE.
- rsp_ready of the non-owning requester SHALL be ignored.
REQ-026 Minimum latency, accept cycle T to first rsp_valid, SHALL be MIN_WAIT+3 cycles.
REQ-027 The counter SHALL be 6 bits and saturate at MAX_CYC; it SHALL never wrap.
REQ-028 rsp_data SHALL retain the last captured value outside RESP.

Reset
REQ-029 On reset low, asynchronously:
- state=IDLE, counter=0, result=0, id=0, pointer favours requester 0;
- req_ready=0, rsp_valid=0, mul_start=0, mul_a=0, mul_b=0, busy=0, rsp_data=0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no rsp_valid.
- The first cycle after release is IDLE.

Structure
REQ-031 Package mult_ctrl_pkg SHALL hold the state enum, the MIN_WAIT/MAX_CYC defaults and the requester count (2).
REQ-032 Round-robin grant logic SHALL be the sub-module rr_arbiter2.
- Inputs: req[1:0], pointer.
- Output: one-hot grant.

Verification
REQ-033 Req0 opA=15, opB=13, rsp_ready=1 -> rsp_valid=2'b01, rsp_data=195, no earlier than MIN_WAIT+3 cycles after accept.
REQ-034 Req1 opA=-15, opB=13 -> rsp_valid=2'b10, rsp_data=0xFFFFFFFFFFFFFF3D.
REQ-035 Both req_valid high from reset, back-to-back -> req0 served first, then req1, then req0 alternating; a waiting requester never waits more than one operation.
REQ-036 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_data held; req_ready stays 0; a single completion on release.
REQ-037 mul_done tied 0 -> completion at count==34, rsp_data = mul_res at that cycle; mul_done tied 1 -> completion at count==2.
REQ-038 reset pulsed low during RUN -> all outputs 0 immediately, no rsp_valid; a fresh request afterwards completes normally.
